rnn_seq_ctrl: RTL and testbench

//  Sequencer for the combinational RNN cell (input->hidden->tanh->output datapath).

---
 rtl/rnn_seq_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_rnn_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rnn_seq_ctrl
//
// Sequencer for a combinational RNN cell (input -> hidden -> tanh -> output).
// Takes one input sample at a time over a valid/ready stream and holds it on
// the cell input bus. At the start of every sequence it clears the cell's
// hidden-state register. It then waits a fixed settle time for the multi-cycle
// combinational path, pulses the hidden-state update, and returns the cell
// output over a valid/ready stream. Only one step is in flight at a time.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      input sample valid
//   in_ready      combinational; high only while idle
//   in_data       input sample (INPUT_SIZE*BW_IN bits)
//   in_first      sample opens a new sequence
//   in_last       sample closes the sequence
//   cell_in       registered sample driven to the cell input bus
//   cell_out      cell output (OUTPUT_SIZE*BW_OUT bits)
//   hs_clear      1-cycle pulse: zero the hidden-state register
//   hs_update     1-cycle pulse: load the activated hidden bus
//   out_valid     output sample valid
//   out_ready     downstream accepts the output
//   out_data      registered cell output
//   out_last      output belongs to the last step of its sequence
//   step_cnt      1-based step index within the sequence (saturates)
//   overrun       sticky: the sequence ran past MAX_STEPS
//   busy_cycles   [RNN_SEQ_PERF_EN only] count of non-idle cycles, wraps
//
// Build option
//   RNN_SEQ_PERF_EN  adds the busy_cycles port and its counter.
// -----------------------------------------------------------------------------
module rnn_seq_ctrl #(
  parameter int INPUT_SIZE    = 1,
  parameter int OUTPUT_SIZE   = 1,
  parameter int BW_IN         = 32,
  parameter int BW_OUT        = 32,
  parameter int SETTLE_CYCLES = 2,   // legal range >= 1
  parameter int MAX_STEPS     = 255,
  parameter int STEP_W        = 8    // 2**STEP_W must exceed MAX_STEPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_SIZE*BW_IN-1:0]   in_data,
  input  logic                          in_first,
  input  logic                          in_last,
  output logic [INPUT_SIZE*BW_IN-1:0]   cell_in,
  input  logic [OUTPUT_SIZE*BW_OUT-1:0] cell_out,
  output logic                          hs_clear,
  output logic                          hs_update,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTPUT_SIZE*BW_OUT-1:0] out_data,
  output logic                          out_last,
  output logic [STEP_W-1:0]             step_cnt,
  output logic                          overrun
`ifdef RNN_SEQ_PERF_EN
  ,
  output logic [31:0]                   busy_cycles
`endif
);

  localparam int IN_W  = INPUT_SIZE * BW_IN;
  localparam int OUT_W = OUTPUT_SIZE * BW_OUT;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  SETTLE_ONE  = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX    = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [IN_W-1:0]   cell_in_q,   cell_in_d;
  logic              last_q,      last_d;
  logic              seq_open_q,  seq_open_d;
  logic [STEP_W-1:0] step_q,      step_d;
  logic              overrun_q,   overrun_d;
  logic [CNT_W-1:0]  settle_q,    settle_d;
  logic              hs_clear_q,  hs_clear_d;
  logic              hs_update_q, hs_update_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic [OUT_W-1:0]  out_data_q,  out_data_d;

  logic accept;
  logic start;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  // A sample opens a sequence when flagged, or implicitly when the previous
  // sequence has already been closed by in_last (or none was ever opened).
  assign start    = in_first | ~seq_open_q;

  // The pulse outputs are registered: they are set on the transition into
  // CLEAR / COMMIT, so each is high for exactly the cycle spent in that state.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cell_in_d   = cell_in_q;
    last_d      = last_q;
    seq_open_d  = seq_open_q;
    step_d      = step_q;
    overrun_d   = overrun_q;
    settle_d    = settle_q;
    hs_clear_d  = 1'b0;
    hs_update_d = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cell_in_d = in_data;
          last_d    = in_last;
          if (start) begin
            step_d     = STEP_ONE;
            overrun_d  = 1'b0;
            seq_open_d = 1'b1;
            hs_clear_d = 1'b1;
            state_d    = S_CLEAR;
          end else begin
            // Saturate the step index; a step past the limit flags overrun
            // but the sample is still processed normally.
            if (step_q == STEP_MAX) begin
              overrun_d = 1'b1;
            end else begin
              step_d = step_q + STEP_ONE;
            end
            settle_d = SETTLE_LOAD;
            state_d  = S_SETTLE;
          end
        end
      end

      S_CLEAR: begin
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_ONE) begin
          hs_update_d = 1'b1;
          state_d     = S_COMMIT;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end

      S_COMMIT: begin
        // cell_out still reflects the pre-update hidden state in this cycle.
        out_data_d  = cell_out;
        out_last_d  = last_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            seq_open_d = 1'b0;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cell_in_q   <= '0;
      last_q      <= 1'b0;
      seq_open_q  <= 1'b0;
      step_q      <= '0;
      overrun_q   <= 1'b0;
      settle_q    <= '0;
      hs_clear_q  <= 1'b0;
      hs_update_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cell_in_q   <= cell_in_d;
      last_q      <= last_d;
      seq_open_q  <= seq_open_d;
      step_q      <= step_d;
      overrun_q   <= overrun_d;
      settle_q    <= settle_d;
      hs_clear_q  <= hs_clear_d;
      hs_update_q <= hs_update_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cell_in   = cell_in_q;
  assign hs_clear  = hs_clear_q;
  assign hs_update = hs_update_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign step_cnt  = step_q;
  assign overrun   = overrun_q;

`ifdef RNN_SEQ_PERF_EN
  logic [31:0] busy_q, busy_d;

  // Free-running count of non-idle cycles; wraps naturally at 2**32.
  assign busy_d = busy_q + {31'd0, (state_q != S_IDLE)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rnn_seq_ctrl
//
// Drives two sequencers with identical stimulus: one with default parameters
// and one with MAX_STEPS=3 / STEP_W=2 so step saturation and overrun are
// reachable in a short sequence. A transaction-level model predicts every
// output from the accept time and the documented latencies; a negedge
// process compares both DUTs against it each cycle. Directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rnn_seq_ctrl;

  localparam int S = 2;  // SETTLE_CYCLES used by both instances

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last, out_ready;
  logic [31:0] in_data;
  logic [31:0] cell_out;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the cell: a value that changes every cycle, so the exact
  // cycle in which cell_out is captured is visible in out_data.
  assign cell_out = 32'hC0DE_0000 + cyc;

  // DUT A: default parameters
  logic        a_in_ready, a_hs_clear, a_hs_update, a_out_valid, a_out_last, a_overrun;
  logic [31:0] a_cell_in, a_out_data;
  logic [7:0]  a_step;
  // DUT B: short sequence limit
  logic        b_in_ready, b_hs_clear, b_hs_update, b_out_valid, b_out_last, b_overrun;
  logic [31:0] b_cell_in, b_out_data;
  logic [1:0]  b_step;
`ifdef RNN_SEQ_PERF_EN
  logic [31:0] a_busy, b_busy;
`endif

  rnn_seq_ctrl #(.SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .cell_in(a_cell_in), .cell_out(cell_out),
    .hs_clear(a_hs_clear), .hs_update(a_hs_update),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .step_cnt(a_step), .overrun(a_overrun)
`ifdef RNN_SEQ_PERF_EN
    , .busy_cycles(a_busy)
`endif
  );

  rnn_seq_ctrl #(.SETTLE_CYCLES(S), .MAX_STEPS(3), .STEP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .cell_in(b_cell_in), .cell_out(cell_out),
    .hs_clear(b_hs_clear), .hs_update(b_hs_update),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .step_cnt(b_step), .overrun(b_overrun)
`ifdef RNN_SEQ_PERF_EN
    , .busy_cycles(b_busy)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model. A step is described only by whether it started a
  // sequence and how many cycles have passed since its accept edge (age=1 is
  // the first cycle after acceptance). Timeline per step:
  //   start step    : clear at age 1, settle ages 2..S+1, update at S+2
  //   non-start step: settle ages 1..S, update at S+1
  //   out_valid from the cycle after the update until the handshake.
  // ---------------------------------------------------------------------------
  bit          m_busy = 0, m_start = 0, m_last = 0, m_seq_open = 0, m_out_last = 0, m_st = 0;
  int          m_age = 0;
  logic [31:0] m_cell_in = '0, m_out_data = '0;
  int          m_step[2] = '{0, 0};
  bit          m_ovr[2] = '{0, 0};
  int          m_max[2] = '{255, 3};
  int unsigned m_busy_cnt = 0;

  function automatic int commit_age();
    return S + 1 + (m_start ? 1 : 0);
  endfunction
  function automatic bit e_clear();   return m_busy && m_start && m_age == 1;   endfunction
  function automatic bit e_update();  return m_busy && m_age == commit_age();  endfunction
  function automatic bit e_valid();   return m_busy && m_age > commit_age();   endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_start = 0; m_last = 0; m_seq_open = 0; m_out_last = 0;
        m_age = 0; m_cell_in = '0; m_out_data = '0; m_busy_cnt = 0;
        for (int i = 0; i < 2; i++) begin m_step[i] = 0; m_ovr[i] = 0; end
      end else begin
        if (m_busy) m_busy_cnt++;
        if (!m_busy) begin
          if (in_valid) begin
            m_st      = in_first || !m_seq_open;
            m_start   = m_st;
            m_busy    = 1;
            m_age     = 1;
            m_cell_in = in_data;
            m_last    = in_last;
            for (int i = 0; i < 2; i++) begin
              if (m_st) begin m_step[i] = 1; m_ovr[i] = 0; end
              else if (m_step[i] == m_max[i]) m_ovr[i] = 1;
              else m_step[i]++;
            end
            if (m_st) m_seq_open = 1;
          end
        end else if (e_valid() && out_ready) begin
          m_busy = 0;
          if (m_out_last) m_seq_open = 0;
        end else begin
          if (m_age == commit_age()) begin
            m_out_data = cell_out;
            m_out_last = m_last;
          end
          m_age++;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model, plus pulse tallies.
  int n_clr = 0, n_upd = 0;
  bit cmp_en = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (a_hs_clear === 1'b1) n_clr++;
      if (a_hs_update === 1'b1) n_upd++;
      if (cmp_en) begin
        check("a_in_ready",  64'(a_in_ready),  64'(!m_busy));
        check("a_hs_clear",  64'(a_hs_clear),  64'(e_clear()));
        check("a_hs_update", 64'(a_hs_update), 64'(e_update()));
        check("a_out_valid", 64'(a_out_valid), 64'(e_valid()));
        check("a_cell_in",   64'(a_cell_in),   64'(m_cell_in));
        check("a_out_data",  64'(a_out_data),  64'(m_out_data));
        check("a_out_last",  64'(a_out_last),  64'(m_out_last));
        check("a_step_cnt",  64'(a_step),      64'(m_step[0]));
        check("a_overrun",   64'(a_overrun),   64'(m_ovr[0]));
        check("b_out_valid", 64'(b_out_valid), 64'(e_valid()));
        check("b_out_data",  64'(b_out_data),  64'(m_out_data));
        check("b_step_cnt",  64'(b_step),      64'(m_step[1]));
        check("b_overrun",   64'(b_overrun),   64'(m_ovr[1]));
`ifdef RNN_SEQ_PERF_EN
        check("a_busy_cycles", 64'(a_busy), 64'(m_busy_cnt));
        check("b_busy_cycles", 64'(b_busy), 64'(m_busy_cnt));
`endif
      end
    end
  end

  // Every stimulus task starts and ends 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input bit f, input bit l);
    int n = 0;
    while (!a_in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("send_ready_timeout", 64'(a_in_ready), 64'(1));
    in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!a_out_valid && n < 100) begin tick(); n++; end
    if (n >= 100) check("out_valid_timeout", 64'(a_out_valid), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  int lat, clr0, upd0;
`ifdef RNN_SEQ_PERF_EN
  logic [31:0] busy0;
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1;
    #1 cmp_en = 1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_step_cnt",  64'(a_step),      64'(0));
    check("rst_cell_in",   64'(a_cell_in),   64'(0));
    check("rst_in_ready",  64'(a_in_ready),  64'(1));

    // 1: one-step sequence, latency counted from the accept cycle
    clr0 = n_clr; upd0 = n_upd;
    in_valid = 1'b1; in_data = 32'd5; in_first = 1'b1; in_last = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!a_out_valid && lat < 50);
    check("t1_latency",  64'(lat),        64'(5));
    check("t1_out_last", 64'(a_out_last), 64'(1));
    check("t1_step_cnt", 64'(a_step),     64'(1));
    check("t1_cell_in",  64'(a_cell_in),  64'(5));
    tick();
    check("t1_released", 64'(a_out_valid),  64'(0));
    check("t1_clears",   64'(n_clr - clr0), 64'(1));
    check("t1_updates",  64'(n_upd - upd0), 64'(1));

    // 2: four-step sequence with out_ready held high
    clr0 = n_clr; upd0 = n_upd;
    for (int k = 0; k < 4; k++) begin
      send(32'd100 + 32'(k), k == 0, k == 3);
      wait_out();
      check("t2_step_cnt", 64'(a_step),     64'(k + 1));
      check("t2_out_last", 64'(a_out_last), 64'(k == 3));
      tick();
    end
    check("t2_clears",  64'(n_clr - clr0), 64'(1));
    check("t2_updates", 64'(n_upd - upd0), 64'(4));

    // 3: downstream stalls for 10 cycles in OUT
    out_ready = 1'b0;
    send(32'hABCD, 1'b1, 1'b0);
    wait_out();
    upd0 = n_upd;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold_valid", 64'(a_out_valid), 64'(1));
      check("t3_in_ready",   64'(a_in_ready),  64'(0));
    end
    check("t3_no_update", 64'(n_upd - upd0), 64'(0));
    out_ready = 1'b1;
    tick();
    check("t3_released", 64'(a_out_valid), 64'(0));

    // 4: run past MAX_STEPS=3 on DUT B, then reopen with in_first
    send(32'd200, 1'b1, 1'b0);
    wait_out(); tick();
    for (int k = 1; k <= 4; k++) begin
      send(32'd200 + 32'(k), 1'b0, 1'b0);
      check("t4_b_overrun",  64'(b_overrun), 64'(k >= 3));
      check("t4_b_step_cnt", 64'(b_step),    64'((k + 1 > 3) ? 3 : k + 1));
      check("t4_a_step_cnt", 64'(a_step),    64'(k + 1));
      wait_out(); tick();
    end
    send(32'd300, 1'b1, 1'b0);
    check("t4_reopen_overrun", 64'(b_overrun), 64'(0));
    check("t4_reopen_step",    64'(b_step),    64'(1));
    wait_out(); tick();

    // 5: reset asserted in SETTLE abandons the step
    send(32'd400, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(a_out_valid), 64'(0));
    check("t5_hs_update", 64'(a_hs_update), 64'(0));
    check("t5_step_cnt",  64'(a_step),      64'(0));
    check("t5_cell_in",   64'(a_cell_in),   64'(0));
    check("t5_out_data",  64'(a_out_data),  64'(0));
    upd0 = n_upd;
    repeat (4) tick();
    check("t5_no_update", 64'(n_upd - upd0), 64'(0));
    rst_n = 1'b1;
    clr0 = n_clr;
    send(32'd500, 1'b0, 1'b1);
    wait_out();
    check("t5_implicit_clear", 64'(n_clr - clr0), 64'(1));
    check("t5_step_cnt_post",  64'(a_step),       64'(1));
    tick();

`ifdef RNN_SEQ_PERF_EN
    // 6: a single non-start step keeps the controller busy SETTLE_CYCLES+2
    send(32'd600, 1'b1, 1'b0);
    wait_out(); tick();
    busy0 = a_busy;
    send(32'd601, 1'b0, 1'b1);
    wait_out(); tick();
    check("t6_busy_cycles", 64'(a_busy - busy0), 64'(S + 2));
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
